// File: rtl/alu_issue_stage.sv
// RV32I OP/OP-IMM operand issue stage: combinational decode into a 2-entry skid buffer
// (main entry M drives outputs, skid entry S absorbs one word while M is stalled).
module alu_issue_stage #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [31:0]            instr_i,
   input  logic [DATA_WIDTH-1:0]  rs1_data_i,
   input  logic [DATA_WIDTH-1:0]  rs2_data_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [DATA_WIDTH-1:0]  operands_a_o,
   output logic [DATA_WIDTH-1:0]  operands_b_o,
   output logic [4:0]             alu_op_o,
   output logic [SHAMT_WIDTH-1:0] shamt_o,
   output logic [4:0]             rd_addr_o,
   output logic                   illegal_o
);

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_AND  = 5'd2;
   localparam logic [4:0] ALU_OR   = 5'd3;
   localparam logic [4:0] ALU_XOR  = 5'd4;
   localparam logic [4:0] ALU_SLL  = 5'd5;
   localparam logic [4:0] ALU_SLT  = 5'd6;
   localparam logic [4:0] ALU_SLTU = 5'd7;
   localparam logic [4:0] ALU_SRL  = 5'd8;
   localparam logic [4:0] ALU_SRA  = 5'd9;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]  a;
      logic [DATA_WIDTH-1:0]  b;
      logic [4:0]             op;
      logic [SHAMT_WIDTH-1:0] shamt;
      logic [4:0]             rd;
      logic                   ill;
   } payload_t;

   logic [6:0] w_opc;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   logic       w_is_op, w_is_imm, w_f7z, w_f7s;
   logic       w_ok, w_shift;
   logic [4:0] w_op;
   payload_t   w_dec;

   assign w_opc    = instr_i[6:0];
   assign w_f3     = instr_i[14:12];
   assign w_f7     = instr_i[31:25];
   assign w_is_op  = (w_opc == OPC_OP);
   assign w_is_imm = (w_opc == OPC_OP_IMM);
   assign w_f7z    = (w_f7 == 7'b0000000);
   assign w_f7s    = (w_f7 == 7'b0100000);

   // Non-shift OP-IMM encodings ignore instr[31:25] (it is immediate), OP requires f7=0
   always_comb begin
      w_ok    = 1'b0;
      w_shift = 1'b0;
      w_op    = ALU_ADD;
      case (w_f3)
         3'b000: begin
            if (w_is_imm || w_f7z) begin w_op = ALU_ADD; w_ok = 1'b1; end
            else if (w_f7s)        begin w_op = ALU_SUB; w_ok = 1'b1; end
         end
         3'b001: if (w_f7z) begin w_op = ALU_SLL; w_ok = 1'b1; w_shift = 1'b1; end
         3'b010: if (w_is_imm || w_f7z) begin w_op = ALU_SLT;  w_ok = 1'b1; end
         3'b011: if (w_is_imm || w_f7z) begin w_op = ALU_SLTU; w_ok = 1'b1; end
         3'b100: if (w_is_imm || w_f7z) begin w_op = ALU_XOR;  w_ok = 1'b1; end
         3'b101: begin
            if (w_f7z)      begin w_op = ALU_SRL; w_ok = 1'b1; w_shift = 1'b1; end
            else if (w_f7s) begin w_op = ALU_SRA; w_ok = 1'b1; w_shift = 1'b1; end
         end
         3'b110: if (w_is_imm || w_f7z) begin w_op = ALU_OR;  w_ok = 1'b1; end
         default: if (w_is_imm || w_f7z) begin w_op = ALU_AND; w_ok = 1'b1; end
      endcase
   end

   always_comb begin
      w_dec = '0;
      if (w_ok && (w_is_op || w_is_imm)) begin
         w_dec.a  = rs1_data_i;
         w_dec.op = w_op;
         w_dec.rd = instr_i[11:7];
         if (w_shift) begin
            // The ALU shifts operand B, so rs1 goes out on both operands
            w_dec.b     = rs1_data_i;
            w_dec.shamt = w_is_op ? rs2_data_i[SHAMT_WIDTH-1:0] : instr_i[20 +: SHAMT_WIDTH];
         end else if (w_is_op) begin
            w_dec.b = rs2_data_i;
         end else begin
            w_dec.b = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
         end
      end else begin
         w_dec.ill = 1'b1;
      end
   end

   logic     r_m_vld, r_s_vld;
   payload_t r_m, r_s;
   logic     w_in_fire, w_m_free;

   assign w_in_fire = in_valid_i & ~r_s_vld;
   assign w_m_free  = ~r_m_vld | out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_m_vld <= 1'b0;
         r_s_vld <= 1'b0;
         r_m     <= '0;
         r_s     <= '0;
      end else if (flush_i) begin
         r_m_vld <= 1'b0;
         r_s_vld <= 1'b0;
      end else if (w_m_free) begin
         if (r_s_vld) begin
            r_m     <= r_s;
            r_m_vld <= 1'b1;
            r_s_vld <= 1'b0;
         end else if (w_in_fire) begin
            r_m     <= w_dec;
            r_m_vld <= 1'b1;
         end else begin
            r_m_vld <= 1'b0;
         end
      end else if (w_in_fire) begin
         r_s     <= w_dec;
         r_s_vld <= 1'b1;
      end
   end

   assign in_ready_o   = ~r_s_vld;
   assign out_valid_o  = r_m_vld;
   assign operands_a_o = r_m.a;
   assign operands_b_o = r_m.b;
   assign alu_op_o     = r_m.op;
   assign shamt_o      = r_m.shamt;
   assign rd_addr_o    = r_m.rd;
   assign illegal_o    = r_m.ill;

endmodule
